// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle writer.
//   FB_WIDTH / FB_HEIGHT : default framebuffer geometry in pixels
//   PIXELS_PER_WORD      : 8-bit palette indices packed per 32-bit BRAM word
//   WORDS_PER_ROW        : BRAM words spanning one framebuffer row
//   state_e              : writer FSM states
//   cmd_t                : one latched rectangle-fill command
package fb_pkg;

  localparam int FB_WIDTH        = 400;
  localparam int FB_HEIGHT       = 300;
  localparam int PIXELS_PER_WORD = 4;
  localparam int WORDS_PER_ROW   = FB_WIDTH / PIXELS_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic [7:0]  color;
  } cmd_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake and BRAM write bus of the rectangle writer.
// Signal suffixes are seen from the writer: _i enters it, _o leaves it.
//   slave  : the writer itself (takes commands, drives the BRAM port)
//   master : the command source / BRAM side (a testbench or a GPU top level)
interface fb_rect_writer_if #(
  parameter int BRAM_ADDR_BITS = 32,
  parameter int BRAM_DATA_BITS = 32
);

  logic                        cmd_valid_i;
  logic                        cmd_ready_o;
  logic [15:0]                 cmd_x_i;
  logic [15:0]                 cmd_y_i;
  logic [15:0]                 cmd_w_i;
  logic [15:0]                 cmd_h_i;
  logic [7:0]                  cmd_color_i;
  logic                        busy_o;
  logic                        done_o;
  logic                        bram_clk_o;
  logic                        bram_rst_o;
  logic                        bram_en_o;
  logic [BRAM_ADDR_BITS-1:0]   bram_addr_o;
  logic [BRAM_DATA_BITS-1:0]   bram_din_o;
  logic [BRAM_DATA_BITS/8-1:0] bram_we_o;
  logic [BRAM_DATA_BITS-1:0]   bram_dout_i;

  modport slave (
    input  cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i,
    input  bram_dout_i,
    output cmd_ready_o, busy_o, done_o,
    output bram_clk_o, bram_rst_o, bram_en_o, bram_addr_o, bram_din_o, bram_we_o
  );

  modport master (
    output cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i,
    output bram_dout_i,
    input  cmd_ready_o, busy_o, done_o,
    input  bram_clk_o, bram_rst_o, bram_en_o, bram_addr_o, bram_din_o, bram_we_o
  );

endinterface

// File: rtl/fb_lane_mask.sv
// Byte-lane write enables for one BRAM word of a clipped rectangle row.
//   word_i       : word index within the row being written
//   first_word_i : first word of the row span (holds pixel x0)
//   last_word_i  : last word of the row span (holds pixel x1-1)
//   x0_lo_i      : x0[1:0], first covered lane of the first word
//   x1m1_lo_i    : (x1-1)[1:0], last covered lane of the last word
//   we_o         : lane i enabled iff pixel 4*word+i lies in [x0, x1)
module fb_lane_mask
  import fb_pkg::*;
(
  input  logic [15:0]                word_i,
  input  logic [15:0]                first_word_i,
  input  logic [15:0]                last_word_i,
  input  logic [1:0]                 x0_lo_i,
  input  logic [1:0]                 x1m1_lo_i,
  output logic [PIXELS_PER_WORD-1:0] we_o
);

  logic is_first;
  logic is_last;

  assign is_first = (word_i == first_word_i);
  assign is_last  = (word_i == last_word_i);

  // A single-word span has both edge rules applied at once.
  for (genvar gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_lane
    assign we_o[gi] = !(is_first && (2'(gi) < x0_lo_i)) &&
                      !(is_last  && (2'(gi) > x1m1_lo_i));
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill producer for the framebuffer BRAM.
// Accepts one command at a time, clips it to the framebuffer, then writes one
// 32-bit word (4 palette indices) per cycle row-major using byte enables.
//   gpu_clk_i : clock (forwarded on bus.bram_clk_o)
//   reset_i   : asynchronous active-high reset (forwarded on bus.bram_rst_o)
//   bus       : command handshake, status (busy/done) and BRAM write port
module fb_rect_writer #(
  parameter int FB_WIDTH       = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT      = fb_pkg::FB_HEIGHT,
  parameter int PALETTE_LENGTH = 256,
  parameter int BRAM_ADDR_BITS = 32,
  parameter int BRAM_DATA_BITS = 32,
  parameter logic [BRAM_ADDR_BITS-1:0] BASE_ADDR = '0
) (
  input  logic           gpu_clk_i,
  input  logic           reset_i,
  fb_rect_writer_if.slave bus
);
  import fb_pkg::*;

  localparam int          WPR    = FB_WIDTH / PIXELS_PER_WORD;
  localparam logic [16:0] FB_W17 = 17'(FB_WIDTH);
  localparam logic [16:0] FB_H17 = 17'(FB_HEIGHT);

  // Geometry the datapath relies on: one pixel per byte lane, whole words per row.
  if (BRAM_DATA_BITS != 32 || $clog2(PALETTE_LENGTH) != 8 ||
      (FB_WIDTH % PIXELS_PER_WORD) != 0) begin : g_bad_params
    $error("fb_rect_writer: unsupported parameter combination");
  end

  state_e      state_q,      state_d;
  cmd_t        cmd_q,        cmd_d;
  logic [15:0] word_q,       word_d;
  logic [15:0] first_word_q, first_word_d;
  logic [15:0] last_word_q,  last_word_d;
  logic [1:0]  x1m1_lo_q,    x1m1_lo_d;
  logic [15:0] y_q,          y_d;
  logic [16:0] y1_q,         y1_d;
  logic [31:0] row_base_q,   row_base_d;

  logic [16:0] x_end, y_end, x1, y1, x1m1;
  logic        rect_empty;
  logic        row_end;
  logic        last_row;
  logic [PIXELS_PER_WORD-1:0] lane_we;
  logic [BRAM_ADDR_BITS-1:0]  word_index;
  logic [BRAM_DATA_BITS-1:0]  unused_dout;

  assign unused_dout = bus.bram_dout_i;

  // Clipping is done in 17 bits so x0+w / y0+h can never wrap.
  always_comb begin
    x_end      = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
    y_end      = {1'b0, cmd_q.y} + {1'b0, cmd_q.h};
    x1         = (x_end > FB_W17) ? FB_W17 : x_end;
    y1         = (y_end > FB_H17) ? FB_H17 : y_end;
    x1m1       = x1 - 17'd1;
    rect_empty = (cmd_q.w == 16'd0) || (cmd_q.h == 16'd0) ||
                 ({1'b0, cmd_q.x} >= FB_W17) || ({1'b0, cmd_q.y} >= FB_H17);
  end

  assign row_end  = (word_q == last_word_q);
  assign last_row = (({1'b0, y_q} + 17'd1) == y1_q);

  fb_lane_mask u_lane_mask (
    .word_i       (word_q),
    .first_word_i (first_word_q),
    .last_word_i  (last_word_q),
    .x0_lo_i      (cmd_q.x[1:0]),
    .x1m1_lo_i    (x1m1_lo_q),
    .we_o         (lane_we)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    word_d       = word_q;
    first_word_d = first_word_q;
    last_word_d  = last_word_q;
    x1m1_lo_d    = x1m1_lo_q;
    y_d          = y_q;
    y1_d         = y1_q;
    row_base_d   = row_base_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          cmd_d.x     = bus.cmd_x_i;
          cmd_d.y     = bus.cmd_y_i;
          cmd_d.w     = bus.cmd_w_i;
          cmd_d.h     = bus.cmd_h_i;
          cmd_d.color = bus.cmd_color_i;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (rect_empty) begin
          state_d = ST_DONE;
        end else begin
          first_word_d = {2'b00, cmd_q.x[15:2]};
          word_d       = {2'b00, cmd_q.x[15:2]};
          last_word_d  = {1'b0, x1m1[16:2]};
          x1m1_lo_d    = x1m1[1:0];
          y_d          = cmd_q.y;
          y1_d         = y1;
          // The only multiply; later rows step by WPR.
          row_base_d   = 32'(cmd_q.y) * 32'(WPR);
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (row_end) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            y_d        = y_q + 16'd1;
            word_d     = first_word_q;
            row_base_d = row_base_q + 32'(WPR);
          end
        end else begin
          word_d = word_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign word_index = BRAM_ADDR_BITS'(row_base_q + 32'(word_q));

  // Outputs decode straight from registered state so an asserted reset
  // silences the BRAM port without waiting for a clock edge.
  always_comb begin
    bus.cmd_ready_o = (state_q == ST_IDLE) && !reset_i;
    bus.busy_o      = (state_q != ST_IDLE);
    bus.done_o      = (state_q == ST_DONE);
    bus.bram_en_o   = 1'b0;
    bus.bram_addr_o = '0;
    bus.bram_din_o  = '0;
    bus.bram_we_o   = '0;
    if (state_q == ST_WRITE) begin
      bus.bram_en_o   = 1'b1;
      bus.bram_addr_o = BASE_ADDR + (word_index << 2);
      bus.bram_din_o  = BRAM_DATA_BITS'({PIXELS_PER_WORD{cmd_q.color}});
      bus.bram_we_o   = lane_we;
    end
  end

  assign bus.bram_clk_o = gpu_clk_i;
  assign bus.bram_rst_o = reset_i;

  always_ff @(posedge gpu_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      word_q       <= '0;
      first_word_q <= '0;
      last_word_q  <= '0;
      x1m1_lo_q    <= '0;
      y_q          <= '0;
      y1_q         <= '0;
      row_base_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      word_q       <= word_d;
      first_word_q <= first_word_d;
      last_word_q  <= last_word_d;
      x1m1_lo_q    <= x1m1_lo_d;
      y_q          <= y_d;
      y1_q         <= y1_d;
      row_base_q   <= row_base_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: a pixel-level model enumerates the
// expected BRAM writes of each accepted command, and a monitor compares every
// cycle's handshake, status and BRAM port against the model's timeline.
module tb_fb_rect_writer;

  localparam int W = 400;
  localparam int H = 300;

  logic gpu_clk_i = 1'b0;
  logic reset_i   = 1'b1;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .gpu_clk_i (gpu_clk_i),
    .reset_i   (reset_i),
    .bus       (bus)
  );

  always #5 gpu_clk_i = ~gpu_clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge gpu_clk_i) cyc <= cyc + 1;

  // Model of the current command: accept cycle, word count, expected writes.
  bit          has_cmd = 1'b0;
  bit          monitor_on = 1'b0;
  int          c0 = 0;
  int          nwords = 0;
  logic [7:0]  exp_color = 8'h00;
  int unsigned exp_addr_q[$];
  logic [3:0]  exp_we_q[$];
  int          writes_seen = 0;
  int          last_done_rel = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Enumerate covered pixels after clipping; one entry per touched word.
  function automatic int model_writes(input int x, input int y, input int w, input int h);
    int x1, y1, n;
    x1 = (x + w > W) ? W : x + w;
    y1 = (y + h > H) ? H : y + h;
    n  = 0;
    if (w == 0 || h == 0 || x >= W || y >= H) return 0;
    for (int r = y; r < y1; r++) begin
      for (int wd = x / 4; wd * 4 < x1; wd++) begin
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
          if (wd * 4 + i >= x && wd * 4 + i < x1) m[i] = 1'b1;
        end
        exp_addr_q.push_back(4 * (r * (W / 4) + wd));
        exp_we_q.push_back(m);
        n++;
      end
    end
    return n;
  endfunction

  // Per-cycle compare against the model timeline.
  initial begin
    forever begin
      bit          busy_exp, en_exp, done_exp;
      int unsigned a;
      logic [3:0]  m;
      @(negedge gpu_clk_i);
      if (monitor_on && !reset_i) begin
        busy_exp = has_cmd && (cyc >= c0 + 1) && (cyc <= c0 + nwords + 2);
        en_exp   = has_cmd && (cyc >= c0 + 2) && (cyc <= c0 + nwords + 1);
        done_exp = has_cmd && (cyc == c0 + nwords + 2);
        chk("cmd_ready_o", bus.cmd_ready_o, !busy_exp);
        chk("busy_o", bus.busy_o, busy_exp);
        chk("done_o", bus.done_o, done_exp);
        chk("bram_en_o", bus.bram_en_o, en_exp);
        if (bus.bram_en_o === 1'b1) begin
          writes_seen++;
          if (exp_addr_q.size() == 0) begin
            chk("unexpected write", 1, 0);
          end else begin
            a = exp_addr_q.pop_front();
            m = exp_we_q.pop_front();
            chk("bram_addr_o", bus.bram_addr_o, a);
            chk("bram_we_o", bus.bram_we_o, m);
            chk("bram_din_o", bus.bram_din_o, {4{exp_color}});
          end
        end else begin
          chk("idle bram_we_o", bus.bram_we_o, 0);
        end
        if (bus.done_o === 1'b1) last_done_rel = cyc - c0;
      end
    end
  end

  task automatic send(input int x, input int y, input int w, input int h,
                      input int col, input bit hold, output int n);
    int waited;
    waited = 0;
    n = 0;
    @(negedge gpu_clk_i);
    bus.cmd_x_i     = 16'(x);
    bus.cmd_y_i     = 16'(y);
    bus.cmd_w_i     = 16'(w);
    bus.cmd_h_i     = 16'(h);
    bus.cmd_color_i = 8'(col);
    bus.cmd_valid_i = 1'b1;
    while (bus.cmd_ready_o !== 1'b1 && waited < 40000) begin
      @(negedge gpu_clk_i);
      waited++;
    end
    if (bus.cmd_ready_o !== 1'b1) begin
      chk("accept timeout", 0, 1);
      finish_now();
    end
    last_done_rel = -1;
    n         = model_writes(x, y, w, h);
    exp_color = 8'(col);
    nwords    = n;
    c0        = cyc;
    has_cmd   = 1'b1;
    $display("cmd x=%0d y=%0d w=%0d h=%0d color=%02h words=%0d accepted at cycle %0d",
             x, y, w, h, col & 8'hFF, n, c0);
    @(posedge gpu_clk_i);
    #1;
    if (!hold) bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int rel);
    int k;
    k   = 0;
    rel = -1;
    @(negedge gpu_clk_i);
    while (bus.cmd_ready_o !== 1'b1 && k < 40000) begin
      @(negedge gpu_clk_i);
      k++;
    end
    if (bus.cmd_ready_o !== 1'b1) begin
      chk("idle timeout", 0, 1);
      finish_now();
    end
    rel = cyc - c0;
    chk("leftover expected writes", exp_addr_q.size(), 0);
  endtask

  initial begin
    int n, n1, n2, rel, cfirst, ws0, k;
    int rx, ry, rw, rh;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_x_i     = '0;
    bus.cmd_y_i     = '0;
    bus.cmd_w_i     = '0;
    bus.cmd_h_i     = '0;
    bus.cmd_color_i = '0;
    bus.bram_dout_i = 32'hDEADBEEF;

    // Reset state.
    #12;
    chk("reset cmd_ready_o", bus.cmd_ready_o, 0);
    chk("reset busy_o", bus.busy_o, 0);
    chk("reset done_o", bus.done_o, 0);
    chk("reset bram_en_o", bus.bram_en_o, 0);
    chk("reset bram_we_o", bus.bram_we_o, 0);
    chk("reset bram_addr_o", bus.bram_addr_o, 0);
    chk("reset bram_din_o", bus.bram_din_o, 0);
    chk("reset bram_rst_o", bus.bram_rst_o, 1);
    @(posedge gpu_clk_i);
    #2;
    reset_i    = 1'b0;
    monitor_on = 1'b1;

    // Basic fill; the model's own list is pinned to hand-computed words.
    send(5, 2, 6, 2, 'h3C, 1'b0, n);
    chk("basic word count", n, 4);
    chk("model basic addr0", exp_addr_q[0], 804);
    chk("model basic we0", exp_we_q[0], 4'b1110);
    chk("model basic addr1", exp_addr_q[1], 808);
    chk("model basic we1", exp_we_q[1], 4'b0111);
    chk("model basic addr2", exp_addr_q[2], 1204);
    chk("model basic addr3", exp_addr_q[3], 1208);
    wait_idle(rel);
    chk("basic done cycle", last_done_rel, 6);
    chk("basic ready cycle", rel, 7);

    // Clipping at the bottom-right corner.
    send(398, 299, 10, 10, 'hA5, 1'b0, n);
    chk("clip word count", n, 1);
    chk("model clip addr", exp_addr_q[0], 119996);
    chk("model clip we", exp_we_q[0], 4'b1100);
    wait_idle(rel);
    chk("clip done cycle", last_done_rel, 3);

    // Empty commands.
    send(10, 10, 0, 5, 'h07, 1'b0, n);
    wait_idle(rel);
    chk("empty w=0 done cycle", last_done_rel, 2);
    chk("empty w=0 ready cycle", rel, 3);
    send(400, 10, 8, 5, 'h07, 1'b0, n);
    wait_idle(rel);
    chk("empty x=400 done cycle", last_done_rel, 2);
    chk("empty x=400 ready cycle", rel, 3);

    // Full clear.
    ws0 = writes_seen;
    send(0, 0, 400, 300, 'h00, 1'b0, n);
    chk("full clear word count", n, 30000);
    wait_idle(rel);
    chk("full clear done cycle", last_done_rel, 30002);
    chk("full clear writes seen", writes_seen - ws0, 30000);

    // Back-to-back with valid held across completion.
    send(17, 40, 13, 3, 'h5A, 1'b1, n1);
    cfirst = c0;
    send(0, 100, 9, 2, 'hC3, 1'b0, n2);
    chk("back-to-back accept gap", c0 - cfirst, n1 + 3);
    wait_idle(rel);

    // Randomized commands, including wide/tall ones exercising the 17-bit clip.
    for (int i = 0; i < 40; i++) begin
      rx = $urandom_range(0, 410);
      ry = $urandom_range(0, 305);
      rw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 48);
      rh = $urandom_range(0, 6);
      if (rw <= 8 && $urandom_range(0, 7) == 0) rh = $urandom_range(0, 65535);
      send(rx, ry, rw, rh, $urandom_range(0, 255),
           (i < 39) && ($urandom_range(0, 1) == 1), n);
    end
    wait_idle(rel);

    // Reset in the middle of a full clear.
    ws0 = writes_seen;
    send(0, 0, 400, 300, 'h11, 1'b0, n);
    k = 0;
    while (writes_seen - ws0 < 100 && k < 1000) begin
      @(negedge gpu_clk_i);
      #2;
      k++;
    end
    chk("reached write 100", writes_seen - ws0, 100);
    reset_i = 1'b1;
    #1;
    chk("async reset bram_en_o", bus.bram_en_o, 0);
    chk("async reset bram_we_o", bus.bram_we_o, 0);
    chk("async reset cmd_ready_o", bus.cmd_ready_o, 0);
    chk("async reset busy_o", bus.busy_o, 0);
    has_cmd = 1'b0;
    exp_addr_q.delete();
    exp_we_q.delete();
    repeat (3) @(posedge gpu_clk_i);
    #2;
    reset_i = 1'b0;
    ws0 = writes_seen;
    repeat (30) @(negedge gpu_clk_i);
    #1;
    chk("post-reset cmd_ready_o", bus.cmd_ready_o, 1);
    chk("post-reset writes", writes_seen - ws0, 0);

    finish_now();
  end

endmodule
